// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lcd_pkg
// Brief    : Opcode constants and sequencer state encoding for lcd_cmd_host.
// Revision : 1.0
// ============================================================================
package lcd_pkg;

    localparam logic [3:0] CMD_WRITE        = 4'd0;
    localparam logic [3:0] CMD_INIT         = 4'd1;
    localparam logic [3:0] CMD_CLEAR        = 4'd2;
    localparam logic [3:0] CMD_DISP_ON      = 4'd3;
    localparam logic [3:0] CMD_DISP_OFF     = 4'd4;
    localparam logic [3:0] CMD_SET_ADDR     = 4'd5;
    localparam logic [3:0] CMD_SET_CONTRAST = 4'd6;
    localparam logic [3:0] CMD_SCROLL       = 4'd7;
    localparam logic [3:0] CMD_INVERT       = 4'd8;
    localparam logic [3:0] CMD_NORMAL       = 4'd9;
    localparam logic [3:0] CMD_SLEEP        = 4'd10;
    localparam logic [3:0] CMD_WAKE         = 4'd11;
    localparam logic [3:0] CMD_INV_THR      = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_BUSY  = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_FINISH     = 3'd5,
        ST_FAULT      = 3'd6
    } lcd_state_t;

    function automatic logic is_write(input logic [3:0] op);
        return op == CMD_WRITE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_host_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Synchronous power-of-two FIFO with full/empty flags and count.
// Revision : 1.0
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage needs no reset: pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_host
// Brief    : Queues upstream LCD opcodes and issues them to the controller.
// Revision : 1.0
// ============================================================================
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    push_cmd,
    input  logic                          push_valid,
    output logic                          push_ready,
    output logic [3:0]                    cmd,
    output logic                          cmd_valid,
    input  logic                          busy,
    input  logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    issued_count,
    output logic                          seq_done,
    output logic                          err_overflow,
    output logic                          err_timeout
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    lcd_state_t        state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        issued_q, issued_d;
    logic              seq_done_q, seq_done_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              closed_q, closed_d;
    logic              push_ready_q, push_ready_d;

    logic              fifo_push, fifo_pop;
    logic [3:0]        fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_cnt, cnt_next;

    assign fifo_push = push_valid && push_ready_q && !fifo_full;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        issued_d    = issued_q;
        seq_done_d  = seq_done_q;
        ovf_d       = ovf_q | (push_valid & ~push_ready_q);
        tmo_d       = tmo_q;
        tmr_d       = tmr_q;
        closed_d    = closed_q;
        fifo_pop    = 1'b0;

        case (state_q)
            // Pop and strobe on the way into ISSUE so cmd_valid is a flop output.
            ST_IDLE: begin
                if (!busy && !fifo_empty) begin
                    state_d     = ST_ISSUE;
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_head;
                    cmd_valid_d = 1'b1;
                    if (issued_q != 8'hFF) begin
                        issued_d = issued_q + 8'd1;
                    end
                    if (is_write(fifo_head)) begin
                        closed_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                tmr_d   = '0;
                state_d = is_write(cmd_q) ? ST_WAIT_DONE : ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    state_d = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (!busy) begin
                    state_d = ST_IDLE;
                end
            end
            // The ISSUE cycle plus the entry cycle account for the two missing counts.
            ST_WAIT_DONE: begin
                if (done) begin
                    state_d    = ST_FINISH;
                    seq_done_d = 1'b1;
                end else if (tmr_q == TMR_W'(TIMEOUT - 2)) begin
                    state_d = ST_FAULT;
                    tmo_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_FINISH: begin
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cnt_next     = fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
        push_ready_d = !closed_d && (state_d != ST_FAULT) && (state_d != ST_FINISH)
                       && (cnt_next < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            issued_q     <= '0;
            seq_done_q   <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
            tmr_q        <= '0;
            closed_q     <= 1'b0;
            push_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            issued_q     <= issued_d;
            seq_done_q   <= seq_done_d;
            ovf_q        <= ovf_d;
            tmo_q        <= tmo_d;
            tmr_q        <= tmr_d;
            closed_q     <= closed_d;
            push_ready_q <= push_ready_d;
        end
    end

    assign push_ready   = push_ready_q;
    assign cmd          = cmd_q;
    assign cmd_valid    = cmd_valid_q;
    assign fifo_count   = fifo_cnt;
    assign issued_count = issued_q;
    assign seq_done     = seq_done_q;
    assign err_overflow = ovf_q;
    assign err_timeout  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_cmd_host
// Brief    : Directed self-checking bench for lcd_cmd_host.
// Revision : 1.0
// ============================================================================
module tb_lcd_cmd_host;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] push_cmd = 4'd0;
    logic       push_valid = 1'b0;
    logic       push_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic [3:0] fifo_count;
    logic [7:0] issued_count;
    logic       seq_done, err_overflow, err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q[$];
    logic [3:0] last_cmd;

    typedef struct {
        logic       pv;
        logic [3:0] pc;
        logic       exp_ready;
        int         exp_count;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[11];

    lcd_cmd_host #(.FIFO_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_cmd     (push_cmd),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .busy         (busy),
        .done         (done),
        .fifo_count   (fifo_count),
        .issued_count (issued_count),
        .seq_done     (seq_done),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag, input int exp_ready);
        check({tag, "_push_ready"}, push_ready, exp_ready);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_issued"}, issued_count, 0);
        check({tag, "_seq_done"}, seq_done, 0);
        check({tag, "_err_ovf"}, err_overflow, 0);
        check({tag, "_err_tmo"}, err_timeout, 0);
    endtask

    task automatic do_reset(input logic busy_val);
        #2;
        reset = 1'b1;
        push_valid = 1'b0;
        done = 1'b0;
        busy = busy_val;
        #1;
        check_reset_vals("rst", 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_push_ready", push_ready, 1);
        check("post_rst_fifo_count", fifo_count, 0);
    endtask

    task automatic push_op(input logic [3:0] op);
        push_valid = 1'b1;
        push_cmd = op;
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    // Controller model: busy rises the cycle after the ISSUE cycle, for one cycle.
    task automatic run_ctrl(input int budget);
        int pend = 0;
        int got = 0;
        int n_exp = exp_q.size();
        int stable_ok = 1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk); #1;
            if (pend == 1) begin
                busy = 1'b1;
                pend = 2;
            end else if (pend == 2) begin
                busy = 1'b0;
                pend = 0;
            end
            if (cmd_valid) begin
                if (got < n_exp) begin
                    check("ctrl_cmd", cmd, exp_q[got]);
                    last_cmd = exp_q[got];
                end
                got++;
                pend = 1;
            end else if (cmd !== last_cmd) begin
                stable_ok = 0;
            end
            if (got >= n_exp && pend == 0) break;
        end
        check("ctrl_pulses", got, n_exp);
        check("cmd_stable", stable_ok, 1);
    endtask

    task automatic wait_issue(input string name);
        int seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (cmd_valid) begin
                seen = 1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int quiet;

        vecs[0]  = '{1'b0, 4'd0,  1'b1, 0, 1'b0};
        vecs[1]  = '{1'b1, 4'd3,  1'b1, 1, 1'b0};
        vecs[2]  = '{1'b1, 4'd7,  1'b1, 2, 1'b0};
        vecs[3]  = '{1'b1, 4'd1,  1'b1, 3, 1'b0};
        vecs[4]  = '{1'b1, 4'd12, 1'b1, 4, 1'b0};
        vecs[5]  = '{1'b1, 4'd13, 1'b1, 5, 1'b0};
        vecs[6]  = '{1'b1, 4'd14, 1'b1, 6, 1'b0};
        vecs[7]  = '{1'b1, 4'd15, 1'b1, 7, 1'b0};
        vecs[8]  = '{1'b1, 4'd2,  1'b0, 8, 1'b0};
        vecs[9]  = '{1'b1, 4'd0,  1'b0, 8, 1'b1};
        vecs[10] = '{1'b0, 4'd0,  1'b0, 8, 1'b1};

        // Reset values and power-up load phase with busy held high.
        @(posedge clk); #1;
        do_reset(1'b1);
        push_op(4'd1);
        quiet = 1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (cmd_valid) quiet = 0;
        end
        check("load_phase_quiet", quiet, 1);
        busy = 1'b0;
        @(posedge clk); #1;
        check("first_issue_valid", cmd_valid, 1);
        check("first_issue_cmd", cmd, 1);
        @(posedge clk); #1;
        check("first_issue_one_cycle", cmd_valid, 0);
        check("first_issue_cmd_hold", cmd, 1);

        // Fill past full with no pops, then drain in order.
        do_reset(1'b1);
        for (int i = 0; i < 11; i++) begin
            push_valid = vecs[i].pv;
            push_cmd = vecs[i].pc;
            @(posedge clk); #1;
            check($sformatf("vec%0d_push_ready", i), push_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_fifo_count", i), fifo_count, vecs[i].exp_count);
            check($sformatf("vec%0d_err_ovf", i), err_overflow, vecs[i].exp_ovf);
        end
        push_valid = 1'b0;
        exp_q = '{4'd3, 4'd7, 4'd1, 4'd12, 4'd13, 4'd14, 4'd15, 4'd2};
        last_cmd = 4'd0;
        busy = 1'b0;
        run_ctrl(200);
        check("drain_issued", issued_count, 8);
        check("drain_fifo_count", fifo_count, 0);
        check("drain_push_ready", push_ready, 1);
        check("drain_ovf_sticky", err_overflow, 1);

        // Ordered issue of {4,5,0} against the controller model.
        do_reset(1'b1);
        push_op(4'd4);
        push_op(4'd5);
        push_op(4'd0);
        check("seq_fifo_count", fifo_count, 3);
        exp_q = '{4'd4, 4'd5, 4'd0};
        last_cmd = 4'd0;
        busy = 1'b0;
        run_ctrl(100);
        check("seq_issued", issued_count, 3);
        check("seq_closed", push_ready, 0);

        // done at cycle 66 after a write issue; done in IDLE ignored first.
        do_reset(1'b0);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        check("idle_done_ignored", seq_done, 0);
        push_op(4'd0);
        wait_issue("write_issue_seen");
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk); #1;
        end
        check("seq_done_c66", seq_done, 0);
        done = 1'b1;
        @(posedge clk); #1;
        check("seq_done_c67", seq_done, 1);
        done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("seq_done_sticky", seq_done, 1);
        check("finish_no_timeout", err_timeout, 0);
        push_op(4'd3);
        check("finish_push_ovf", err_overflow, 1);
        check("finish_push_ready", push_ready, 0);
        check("finish_fifo_count", fifo_count, 0);

        // Timeout: err_timeout rises exactly TIMEOUT cycles after the issue.
        do_reset(1'b0);
        push_op(4'd0);
        wait_issue("tmo_issue_seen");
        for (int c = 1; c <= TIMEOUT - 1; c++) begin
            @(posedge clk); #1;
        end
        check("tmo_before", err_timeout, 0);
        @(posedge clk); #1;
        check("tmo_at", err_timeout, 1);
        push_op(4'd5);
        check("fault_push_ovf", err_overflow, 1);
        check("fault_push_ready", push_ready, 0);
        check("fault_fifo_count", fifo_count, 0);
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(posedge clk); #1;
        check("fault_absorbing", seq_done, 0);
        check("fault_no_cmd_valid", cmd_valid, 0);

        // Reset mid-sequence in WAIT_BUSY with 3 entries queued.
        do_reset(1'b1);
        push_op(4'd2);
        push_op(4'd3);
        push_op(4'd6);
        push_op(4'd7);
        check("mid_fifo_count4", fifo_count, 4);
        busy = 1'b0;
        @(posedge clk); #1;
        check("mid_issue_valid", cmd_valid, 1);
        check("mid_issue_cmd", cmd, 2);
        @(posedge clk); #1;
        check("mid_fifo_count3", fifo_count, 3);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid_rst", 0);
        @(posedge clk); #1;
        reset = 1'b0;
        quiet = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (cmd_valid) quiet = 0;
        end
        check("mid_no_stale_issue", quiet, 1);
        check("mid_post_fifo_count", fifo_count, 0);
        check("mid_post_issued", issued_count, 0);
        check("mid_post_push_ready", push_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
